icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_if.sv | 25 ++
 rtl/icache.sv | 204 ++++++++++++++++++++
 tb/tb_icache.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache, grouped as one bundle.
// slave = the cache itself, master = the ifetch/memory environment driving it.
interface icache_if;
    logic        to_icache;
    logic [31:0] pc_to_icache;
    logic        clear_in;
    logic        have_result;
    logic [31:0] inst_from_icache;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;

    // Handshakes: to_icache and have_result are one-cycle strobes; mem_req is held
    // high with a stable mem_addr until mem_ready is sampled, which completes the word.
    modport slave (
        input  to_icache, pc_to_icache, clear_in, mem_ready, mem_data,
        output have_result, inst_from_icache, mem_req, mem_addr
    );

    modport master (
        output to_icache, pc_to_icache, clear_in, mem_ready, mem_data,
        input  have_result, inst_from_icache, mem_req, mem_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache (IDLE/REFILL/RESPOND) between ifetch and the memory controller.
// Define ICACHE_EN to build the cache; without it every fetch becomes a single-word read of pc.
module icache #(
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    icache_if.slave    bus,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        have_result_q, have_result_d;
    logic [31:0] inst_q, inst_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        abort_q, abort_d;

    assign bus.have_result      = have_result_q;
    assign bus.inst_from_icache = inst_q;
    assign bus.mem_req          = mem_req_q;
    assign bus.mem_addr         = mem_addr_q;
    assign state_dbg            = state_q;

`ifdef ICACHE_EN
    localparam int TAG_W = 30 - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;

    logic [LINES-1:0]    valid_q, valid_d;
    logic [29:0]         pcw_q, pcw_d;
    logic [OFFSET_W-1:0] cnt_q, cnt_d;

    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [31:0]         data_mem [LINES*WORDS];

    logic [OFFSET_W-1:0] req_off, line_off;
    logic [INDEX_W-1:0]  req_idx, line_idx;
    logic [TAG_W-1:0]    req_tag, line_tag;
    logic                req_hit;
    logic                data_we, tag_we;
    logic [1:0]          unused_pc_lo;

    assign req_off      = bus.pc_to_icache[OFFSET_W+1:2];
    assign req_idx      = bus.pc_to_icache[OFFSET_W+INDEX_W+1:OFFSET_W+2];
    assign req_tag      = bus.pc_to_icache[31:OFFSET_W+INDEX_W+2];
    assign unused_pc_lo = bus.pc_to_icache[1:0];

    // Line under refill comes from the latched word address, not the live pc.
    assign line_off = pcw_q[OFFSET_W-1:0];
    assign line_idx = pcw_q[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign line_tag = pcw_q[29:OFFSET_W+INDEX_W];

    assign req_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    always_comb begin
        state_d       = state_q;
        have_result_d = 1'b0;
        inst_d        = inst_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        abort_d       = abort_q;
        valid_d       = valid_q;
        pcw_d         = pcw_q;
        cnt_d         = cnt_q;
        data_we       = 1'b0;
        tag_we        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.clear_in && bus.to_icache) begin
                    if (req_hit) begin
                        have_result_d = 1'b1;
                        inst_d        = data_mem[{req_idx, req_off}];
                    end else begin
                        // The victim line is invalid from the first refill word on,
                        // so an aborted refill never leaves a half-written valid line.
                        valid_d[req_idx] = 1'b0;
                        pcw_d            = bus.pc_to_icache[31:2];
                        cnt_d            = '0;
                        abort_d          = 1'b0;
                        mem_req_d        = 1'b1;
                        mem_addr_d       = {bus.pc_to_icache[31:OFFSET_W+2], {OFFSET_W{1'b0}}, 2'b00};
                        state_d          = REFILL;
                    end
                end
            end
            REFILL: begin
                if (mem_req_q) begin
                    if (bus.mem_ready) begin
                        mem_req_d = 1'b0;
                        data_we   = 1'b1;
                        if (abort_q || bus.clear_in) begin
                            state_d = IDLE;
                        end else if (cnt_q == OFFSET_W'(WORDS - 1)) begin
                            valid_d[line_idx] = 1'b1;
                            tag_we            = 1'b1;
                            have_result_d     = 1'b1;
                            inst_d            = (line_off == cnt_q) ? bus.mem_data
                                                                    : data_mem[{line_idx, line_off}];
                            state_d           = RESPOND;
                        end else begin
                            cnt_d = cnt_q + OFFSET_W'(1);
                        end
                    end else if (bus.clear_in) begin
                        abort_d = 1'b1;
                    end
                end else if (bus.clear_in) begin
                    state_d = IDLE;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pcw_q[29:OFFSET_W], cnt_q, 2'b00};
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= '0;
            pcw_q   <= '0;
            cnt_q   <= '0;
        end else if (rdy_in) begin
            valid_q <= valid_d;
            pcw_q   <= pcw_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && data_we) begin
            data_mem[{line_idx, cnt_q}] <= bus.mem_data;
        end
        if (rdy_in && tag_we) begin
            tag_mem[line_idx] <= line_tag;
        end
    end
`else
    logic [INDEX_W+OFFSET_W+1:0] unused_geom;
    assign unused_geom = bus.pc_to_icache[INDEX_W+OFFSET_W+1:0];

    always_comb begin
        state_d       = state_q;
        have_result_d = 1'b0;
        inst_d        = inst_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        abort_d       = abort_q;
        case (state_q)
            IDLE: begin
                if (!bus.clear_in && bus.to_icache) begin
                    abort_d    = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {bus.pc_to_icache[31:2], 2'b00};
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    if (abort_q || bus.clear_in) begin
                        state_d = IDLE;
                    end else begin
                        have_result_d = 1'b1;
                        inst_d        = bus.mem_data;
                        state_d       = RESPOND;
                    end
                end else if (bus.clear_in) begin
                    abort_d = 1'b1;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
`endif

    // A low rdy_in freezes every register, including the one-cycle strobes.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            have_result_q <= 1'b0;
            inst_q        <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            abort_q       <= 1'b0;
        end else if (rdy_in) begin
            state_q       <= state_d;
            have_result_q <= have_result_d;
            inst_q        <= inst_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            abort_q       <= abort_d;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: table of fetches plus flush, stall, same-cycle clear and reset sequences.
// Expectations adapt to whether ICACHE_EN is defined (cache) or not (single-word bypass).
module tb_icache;
    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       rdy_in;
    logic [1:0] state_dbg;

    icache_if bus();

    icache dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int tick_no = 0;
    int req_tick = 0;
    int last_acc_tick = 0;
    int acc_count = 0;
    int stall_pulses = 0;

    // Scoreboard: expected memory addresses and expected instruction results.
    logic [31:0] exp_q[$];
    logic [31:0] exp_res_q[$];
    logic        exp_hit_q[$];

    // Memory responder state.
    int          lat = 3;
    logic        pending = 1'b0;
    int          cnt = 0;
    logic [31:0] served_addr = '0;

    typedef struct {
        logic [31:0] pc;
        int          lat;
        logic        exp_hit;
    } vec_t;
    vec_t vecs[11];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    // One clock: responder acts on what the DUT sampled at this edge, then outputs are checked.
    task automatic tick();
        logic rdy_was;
        logic hit;
        rdy_was = rdy_in;
        @(posedge clk_in);
        #1;
        tick_no++;
        if (bus.mem_ready) begin
            bus.mem_ready = 1'b0;
            if (!rdy_was) begin
                stall_pulses++;
            end else begin
                acc_count++;
                last_acc_tick = tick_no;
                if (exp_q.size() == 0) fail_now("extra_mem_req");
                else check("mem_addr", served_addr, exp_q.pop_front());
            end
        end else if (bus.mem_req && !pending) begin
            pending     = 1'b1;
            cnt         = lat;
            served_addr = bus.mem_addr;
        end
        if (pending) begin
            cnt--;
            if (cnt <= 0) begin
                pending       = 1'b0;
                bus.mem_ready = 1'b1;
                bus.mem_data  = mem_word(served_addr);
            end
        end
        if (bus.have_result) begin
            if (exp_res_q.size() == 0) begin
                fail_now("spurious_have_result");
            end else begin
                hit = exp_hit_q.pop_front();
                check("inst", bus.inst_from_icache, exp_res_q.pop_front());
                check("result_tick", 32'(tick_no), hit ? 32'(req_tick) : 32'(last_acc_tick));
            end
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc, input logic is_hit);
        logic hit;
        hit = is_hit;
`ifdef ICACHE_EN
        if (!hit) begin
            for (int w = 0; w < 4; w++) exp_q.push_back({pc[31:4], 2'(w), 2'b00});
        end
`else
        hit = 1'b0;
        exp_q.push_back({pc[31:2], 2'b00});
`endif
        exp_res_q.push_back(mem_word({pc[31:2], 2'b00}));
        exp_hit_q.push_back(hit);
    endtask

    task automatic drive_req(input logic [31:0] pc, input logic clr);
        bus.to_icache    = 1'b1;
        bus.pc_to_icache = pc;
        bus.clear_in     = clr;
        req_tick         = tick_no + 1;
        tick();
        bus.to_icache    = 1'b0;
        bus.clear_in     = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_res_q.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) fail_now("timeout_wait_done");
        repeat (8) tick();
        check("addr_left", 32'(exp_q.size()), 32'd0);
        check("result_left", 32'(exp_res_q.size()), 32'd0);
    endtask

    // Wait until `target` words have been accepted and the next request is in flight.
    task automatic wait_inflight(input int target);
        int n;
        n = 0;
        while (!(acc_count >= target && bus.mem_req && !bus.mem_ready) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) fail_now("timeout_wait_inflight");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        vecs[0]  = '{32'h0000_0108, 3, 1'b0};
        vecs[1]  = '{32'h0000_0104, 3, 1'b1};
        vecs[2]  = '{32'h0000_010C, 3, 1'b1};
        vecs[3]  = '{32'h0000_0508, 2, 1'b0};
        vecs[4]  = '{32'h0000_050C, 2, 1'b1};
        vecs[5]  = '{32'h0000_0108, 4, 1'b0};
        vecs[6]  = '{32'h0000_0000, 1, 1'b0};
        vecs[7]  = '{32'h0000_03FC, 1, 1'b0};
        vecs[8]  = '{32'h0000_03F0, 3, 1'b1};
        vecs[9]  = '{32'hFFFF_FFFC, 2, 1'b0};
        vecs[10] = '{32'h0000_03F0, 0, 1'b0};

        rst_in           = 1'b0;
        rdy_in           = 1'b1;
        bus.to_icache    = 1'b0;
        bus.pc_to_icache = '0;
        bus.clear_in     = 1'b0;
        bus.mem_ready    = 1'b0;
        bus.mem_data     = '0;

        // Reset values before any clock edge.
        #2;
        check("rst_have_result", {31'd0, bus.have_result}, 32'd0);
        check("rst_inst", bus.inst_from_icache, 32'd0);
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        tick();
        tick();
        rst_in = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            lat = (vecs[i].lat == 0) ? int'($urandom_range(1, 4)) : vecs[i].lat;
            expect_fetch(vecs[i].pc, vecs[i].exp_hit);
            drive_req(vecs[i].pc, 1'b0);
            wait_done();
        end

        // clear_in with a same-cycle request (a hit in cache mode): no result, no refill.
        drive_req(32'h0000_03F0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("clr_hit_have_result", {31'd0, bus.have_result}, 32'd0);
            check("clr_hit_mem_req", {31'd0, bus.mem_req}, 32'd0);
            tick();
        end
        wait_done();

        // Flush during a refill word: that word completes, nothing further, no result.
        lat = 3;
`ifdef ICACHE_EN
        k = 1;
        exp_q.push_back(32'h0000_0700);
        exp_q.push_back(32'h0000_0704);
`else
        k = 0;
        exp_q.push_back(32'h0000_0700);
`endif
        k = k + acc_count;
        drive_req(32'h0000_0700, 1'b0);
        wait_inflight(k);
        bus.clear_in = 1'b1;
        tick();
        bus.clear_in = 1'b0;
        wait_done();
        check("flush_state", {30'd0, state_dbg}, 32'd0);
        expect_fetch(32'h0000_0700, 1'b0);
        drive_req(32'h0000_0700, 1'b0);
        wait_done();

        // Stall: rdy_in low for 5 cycles while memory pulses mem_ready.
        lat = 3;
        expect_fetch(32'h0000_0800, 1'b0);
`ifdef ICACHE_EN
        k = 1 + acc_count;
`else
        k = acc_count;
`endif
        drive_req(32'h0000_0800, 1'b0);
        wait_inflight(k);
        stall_pulses = 0;
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_mem_req", {31'd0, bus.mem_req}, 32'd1);
            check("stall_mem_addr", bus.mem_addr, exp_q[0]);
            check("stall_have_result", {31'd0, bus.have_result}, 32'd0);
            check("stall_state", {30'd0, state_dbg}, 32'd1);
        end
        rdy_in = 1'b1;
        check("stall_pulse_seen", 32'(stall_pulses > 0), 32'd1);
        wait_done();

        // Two fetches of the same pc: bypass reads memory twice, the cache only once.
        lat = 2;
        expect_fetch(32'h0000_0200, 1'b0);
        drive_req(32'h0000_0200, 1'b0);
        wait_done();
        expect_fetch(32'h0000_0200, 1'b1);
        drive_req(32'h0000_0200, 1'b0);
        wait_done();

        // Asynchronous reset in the middle of a refill.
        lat = 4;
        exp_q.push_back(32'h0000_0900);
        drive_req(32'h0000_0900, 1'b0);
        #3;
        rst_in = 1'b0;
        #1;
        check("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("midrst_mem_addr", bus.mem_addr, 32'd0);
        check("midrst_inst", bus.inst_from_icache, 32'd0);
        check("midrst_state", {30'd0, state_dbg}, 32'd0);
        bus.mem_ready = 1'b0;
        pending = 1'b0;
        exp_q.delete();
        exp_res_q.delete();
        exp_hit_q.delete();
        tick();
        rst_in = 1'b1;
        tick();
        // Valid bits were cleared, so a previously cached line misses again.
        expect_fetch(32'h0000_0104, 1'b0);
        drive_req(32'h0000_0104, 1'b0);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
